// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: 2**ADDR_W x DATA_W RAM with one-cycle reads,
// a memory-mapped result register, and a clear -> load -> run boot sequence.
module cpu_mem_responder #(
  parameter int unsigned      ADDR_W         = 8,
  parameter int unsigned      DATA_W         = 16,
  parameter logic [ADDR_W-1:0] RESULT_ADDR   = {ADDR_W{1'b1}},
  parameter bit               CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_LOAD;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_res;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign is_res = (cpu_addr == RESULT_ADDR);

  // Boot sequencing, registered read path and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_STATE;
      clr_cnt   <= '0;
      cpu_rdata <= '0;
      cpu_rst_n <= 1'b0;
      ld_ready  <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == {ADDR_W{1'b1}}) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_done) begin
            state     <= S_RUN;
            ld_ready  <= 1'b0;
            cpu_rst_n <= 1'b1;
          end else begin
            ld_ready <= 1'b1;
          end
        end
        S_RUN: begin
          // Result register read returns the pre-write value, matching RAM read-before-write.
          cpu_rdata <= is_res ? res_data : mem[cpu_addr];
          if (cpu_we && is_res) begin
            res_data  <= cpu_wdata;
            res_valid <= 1'b1;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

  // Single RAM write port; the owner is selected by the boot phase.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cpu_addr;
    wr_data = cpu_wdata;
    unique case (state)
      S_CLEAR: begin
        wr_en   = ~rst;
        wr_addr = clr_cnt;
        wr_data = '0;
      end
      S_LOAD: begin
        wr_en   = ld_valid & ld_ready;
        wr_addr = ld_addr;
        wr_data = ld_data;
      end
      S_RUN:   wr_en = cpu_we & ~is_res;
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized/directed bench for cpu_mem_responder against an array-based memory model.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_done;
  logic [15:0] res_data;
  logic        res_valid;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] m_mem [256];
  logic [15:0] m_res;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_rst_n(cpu_rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done),
    .res_data(res_data), .res_valid(res_valid)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"},     cpu_rdata, 16'h0000);
    chk({tag, "_cpu_rst_n"}, 16'(cpu_rst_n), 16'h0);
    chk({tag, "_ld_ready"},  16'(ld_ready), 16'h0);
    chk({tag, "_res_data"},  res_data, 16'h0000);
    chk({tag, "_res_valid"}, 16'(res_valid), 16'h0);
  endtask

  // Reset asserted between clock edges; outputs must respond without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs(tag);
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    cpu_we   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 256 clear cycles after reset release; ld_ready must rise on exactly the 256th edge.
  task automatic clear_phase();
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("clr_ld_ready",  16'(ld_ready), 16'(i == 256));
      chk("clr_cpu_rst_n", 16'(cpu_rst_n), 16'h0);
      chk("clr_res_valid", 16'(res_valid), 16'h0);
      chk("clr_rdata",     cpu_rdata, 16'h0000);
      if (i == 100) begin
        chk("clr_peek_mem3",  dut.mem[3], 16'h0000);
        chk("clr_peek_mem5",  dut.mem[5], 16'h0000);
        chk("clr_peek_mem50", dut.mem[50], 16'h0000);
      end
    end
    for (int a = 0; a < 256; a++) m_mem[a] = 16'h0000;
    m_res = 16'h0000;
  endtask

  task automatic load(input logic [7:0] addr, input logic [15:0] data, input logic done);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    ld_done  = done;
    step();
    m_mem[addr] = data;
    chk("load_ld_ready",  16'(ld_ready), 16'(!done));
    chk("load_cpu_rst_n", 16'(cpu_rst_n), 16'(done));
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  task automatic cpu(input logic [7:0] addr, input logic we, input logic [15:0] wdata);
    logic [15:0] exp_rd;
    logic        exp_v;
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_wdata = wdata;
    exp_rd = (addr == 8'hFF) ? m_res : m_mem[addr];
    exp_v  = we && (addr == 8'hFF);
    if (we) begin
      if (addr == 8'hFF) m_res = wdata;
      else               m_mem[addr] = wdata;
    end
    step();
    chk("run_rdata",     cpu_rdata, exp_rd);
    chk("run_res_valid", 16'(res_valid), 16'(exp_v));
    chk("run_res_data",  res_data, m_res);
    chk("run_cpu_rst_n", 16'(cpu_rst_n), 16'h1);
    cpu_we = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rd;
    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    m_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");

    // Loader and CPU both active during CLEAR: neither may touch RAM.
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 16'hAAAA;
    cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 16'h5555;
    rst = 1'b0;
    clear_phase();
    cpu_we = 1'b0;
    step();
    m_mem[5] = 16'hAAAA;
    chk("first_accept_mem5", dut.mem[5], 16'hAAAA);
    chk("first_accept_mem3", dut.mem[3], 16'h0000);
    ld_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(100, 200));
      rd = 16'($urandom);
      load(ra, rd, 1'b0);
    end
    load(8'hFF, 16'hBEEF, 1'b0);
    load(8'd0,  16'h0232, 1'b0);
    load(8'd1,  16'h013C, 1'b0);
    load(8'd50, 16'h00FF, 1'b1);

    cpu(8'd0,  1'b0, 16'h0);
    chk("dir_read0", cpu_rdata, 16'h0232);
    cpu(8'd50, 1'b0, 16'h0);
    chk("dir_read50", cpu_rdata, 16'h00FF);
    cpu(8'd1,  1'b0, 16'h0);
    cpu(8'd5,  1'b0, 16'h0);
    cpu(8'd60, 1'b1, 16'hFFF4);
    chk("rbw_old", cpu_rdata, 16'h0000);
    cpu(8'd60, 1'b0, 16'h0);
    chk("rbw_new", cpu_rdata, 16'hFFF4);
    cpu(8'hFF, 1'b1, 16'h1234);
    chk("res_write_data", res_data, 16'h1234);
    chk("res_write_valid", 16'(res_valid), 16'h1);
    cpu(8'hFF, 1'b0, 16'h0);
    chk("res_read", cpu_rdata, 16'h1234);
    chk("res_valid_drop", 16'(res_valid), 16'h0);
    chk("res_shadow_mem255", dut.mem[255], 16'hBEEF);
    cpu(8'hFF, 1'b1, 16'h1111);
    cpu(8'hFF, 1'b1, 16'h2222);
    chk("res_b2b_data", res_data, 16'h2222);

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      cpu(ra, 1'($urandom_range(0, 1)), 16'($urandom));
    end
    chk("rand_shadow_mem255", dut.mem[255], m_mem[255]);

    // Reset during RUN, then a fresh clear with a CPU write attempt in flight.
    async_reset("rst_run");
    cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 16'h5555;
    clear_phase();
    cpu_we = 1'b0;
    chk("reclear_mem60", dut.mem[60], 16'h0000);
    chk("reclear_mem0",  dut.mem[0], 16'h0000);
    chk("reclear_mem3",  dut.mem[3], 16'h0000);

    // Reset during LOAD discards what was loaded.
    load(8'd7, 16'h7777, 1'b0);
    chk("preload_mem7", dut.mem[7], 16'h7777);
    async_reset("rst_load");
    clear_phase();
    chk("reclear_mem7", dut.mem[7], 16'h0000);
    load(8'd9, 16'h0909, 1'b1);
    cpu(8'd9, 1'b0, 16'h0);
    cpu(8'd7, 1'b0, 16'h0);
    cpu(8'hFF, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
